// File: rtl/prange_gen.sv
// Streams range(base, limit, step) as NUM_OUT-lane beats over a ready/valid handshake.
// MODE 0 puts the same value on every lane; MODE 1 strides lanes by step.
// state | meaning
// RUN   | a beat is held on the outputs or is about to be
// DONE  | idle, sequence finished, _done high
module prange_gen #(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 2,
    parameter int MODE    = 0
) (
    input  logic                       _clock,
    input  logic                       _reset,
    input  logic                       _start,
    input  logic [WIDTH-1:0]           base,
    input  logic [WIDTH-1:0]           limit,
    input  logic [WIDTH-1:0]           step,
    input  logic                       _ready,
    output logic                       _valid,
    output logic                       _done,
    output logic [NUM_OUT*WIDTH-1:0]   _out,
    output logic [NUM_OUT-1:0]         _mask,
    output logic [31:0]                _index
);

    localparam int EW = WIDTH + $clog2(NUM_OUT) + 2;
    typedef logic signed [EW-1:0] ext_t;
    typedef enum logic {RUN, DONE} state_t;

    localparam ext_t ZERO = '0;
    localparam ext_t MAXV = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam ext_t MINV = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam ext_t NX   = ext_t'(NUM_OUT);

    state_t state;
    ext_t   cur_i, step_r, limit_r, adv;
    ext_t   step_x, limit_x, head, lane_v;
    logic   head_ok;
    logic [NUM_OUT-1:0]       lane_ok;
    logic [NUM_OUT*WIDTH-1:0] lane_bus;

    function automatic ext_t sext(input logic [WIDTH-1:0] v);
        return $signed({{(EW-WIDTH){v[WIDTH-1]}}, v});
    endfunction

    // Anything outside the signed WIDTH range counts as out of range, so values never wrap.
    function automatic logic in_range(input ext_t v, input ext_t st, input ext_t lim);
        return (v >= MINV) && (v <= MAXV) &&
               (((st > ZERO) && (v < lim)) || ((st < ZERO) && (v > lim)));
    endfunction

    assign adv = (MODE == 1) ? step_r * NX : step_r;

    // head is the lane-0 value of the beat that would be loaded at this edge.
    always_comb begin
        step_x   = _start ? sext(step)  : step_r;
        limit_x  = _start ? sext(limit) : limit_r;
        head     = _start ? sext(base)  : cur_i + adv;
        head_ok  = in_range(head, step_x, limit_x);
        lane_v   = head;
        lane_ok  = '0;
        lane_bus = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            lane_v = (MODE == 1) ? head + ext_t'(k) * step_x : head;
            lane_bus[k*WIDTH +: WIDTH] = lane_v[WIDTH-1:0];
            lane_ok[k] = (MODE == 1) ? in_range(lane_v, step_x, limit_x) : 1'b1;
        end
    end

    always_ff @(posedge _clock) begin
        if (_start) begin
            step_r  <= step_x;
            limit_r <= limit_x;
            _index  <= '0;
            if (head_ok) begin
                state  <= RUN;
                cur_i  <= head;
                _out   <= lane_bus;
                _mask  <= lane_ok;
                _valid <= 1'b1;
                _done  <= 1'b0;
            end else begin
                state  <= DONE;
                _valid <= 1'b0;
                _done  <= 1'b1;
            end
        end else if (_reset) begin
            state  <= DONE;
            _valid <= 1'b0;
            _done  <= 1'b0;
            _out   <= '0;
            _mask  <= '0;
            _index <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (_ready) begin
                        if (head_ok) begin
                            cur_i  <= head;
                            _out   <= lane_bus;
                            _mask  <= lane_ok;
                            _index <= _index + 32'd1;
                        end else begin
                            state  <= DONE;
                            _valid <= 1'b0;
                            _done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    _valid <= 1'b0;
                    _done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prange_gen.sv
// Directed bench for prange_gen: duplicate, stride, negative step, empty ranges,
// backpressure, restart, narrow-width overflow and reset/start interaction.
module tb_prange_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: duplicate mode, 32-bit, 2 lanes
    logic        start_a, ready_a, valid_a, done_a;
    logic [31:0] base_a, limit_a, step_a, index_a;
    logic [63:0] out_a;
    logic [1:0]  mask_a;
    // B: stride mode, 32-bit, 4 lanes
    logic         start_b, ready_b, valid_b, done_b;
    logic [31:0]  base_b, limit_b, step_b, index_b;
    logic [127:0] out_b;
    logic [3:0]   mask_b;
    // C: duplicate mode, 8-bit, 1 lane
    logic        start_c, ready_c, valid_c, done_c;
    logic [7:0]  base_c, limit_c, step_c, out_c;
    logic [31:0] index_c;
    logic [0:0]  mask_c;

    prange_gen #(.WIDTH(32), .NUM_OUT(2), .MODE(0)) dut_a (
        ._clock(clk), ._reset(rst), ._start(start_a), .base(base_a), .limit(limit_a),
        .step(step_a), ._ready(ready_a), ._valid(valid_a), ._done(done_a),
        ._out(out_a), ._mask(mask_a), ._index(index_a));

    prange_gen #(.WIDTH(32), .NUM_OUT(4), .MODE(1)) dut_b (
        ._clock(clk), ._reset(rst), ._start(start_b), .base(base_b), .limit(limit_b),
        .step(step_b), ._ready(ready_b), ._valid(valid_b), ._done(done_b),
        ._out(out_b), ._mask(mask_b), ._index(index_b));

    prange_gen #(.WIDTH(8), .NUM_OUT(1), .MODE(0)) dut_c (
        ._clock(clk), ._reset(rst), ._start(start_c), .base(base_c), .limit(limit_c),
        .step(step_c), ._ready(ready_c), ._valid(valid_c), ._done(done_c),
        ._out(out_c), ._mask(mask_c), ._index(index_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dup(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s);
        start_a = 1'b1; base_a = b; limit_a = l; step_a = s;
        tick();
        start_a = 1'b0;
    endtask

    task automatic expect_a_beat(input string tag, input logic [31:0] v, input logic [31:0] idx);
        checks++;
        if (valid_a !== 1'b1 || out_a !== {v, v} || mask_a !== 2'b11 || index_a !== idx) begin
            errors++;
            $display("FAIL %s: got valid=%0b out=%h mask=%b idx=%0d, want valid=1 out=%h mask=11 idx=%0d",
                     tag, valid_a, out_a, mask_a, index_a, {v, v}, idx);
        end
    endtask

    task automatic expect_a_done(input string tag);
        checks++;
        if (valid_a !== 1'b0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL %s: got valid=%0b done=%0b, want valid=0 done=1", tag, valid_a, done_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
        tick(); tick();
        checks++;
        if (valid_a !== 1'b0 || done_a !== 1'b0 || out_a !== 64'd0 || mask_a !== 2'b00 || index_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_a: got valid=%0b done=%0b out=%h mask=%b idx=%0d, want all 0",
                     valid_a, done_a, out_a, mask_a, index_a);
        end
        checks++;
        if (valid_b !== 1'b0 || done_b !== 1'b0 || valid_c !== 1'b0 || done_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_bc: got vb=%0b db=%0b vc=%0b dc=%0b, want 0", valid_b, done_b, valid_c, done_c);
        end
        rst = 1'b0;
        tick();
        expect_a_done("reset_done_rise");
    endtask

    task automatic test_duplicate();
        ready_a = 1'b1;
        start_dup(32'd1, 32'd11, 32'd3);
        for (int b = 0; b < 4; b++) begin
            expect_a_beat("dup_beat", 32'(1 + 3 * b), 32'(b));
            tick();
        end
        expect_a_done("dup_done");
    endtask

    task automatic test_backpressure();
        ready_a = 1'b1;
        start_dup(32'd1, 32'd11, 32'd3);
        expect_a_beat("bp_beat0", 32'd1, 32'd0);
        tick();
        expect_a_beat("bp_beat1", 32'd4, 32'd1);
        ready_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_a_beat("bp_hold", 32'd4, 32'd1);
        end
        ready_a = 1'b1;
        tick();
        expect_a_beat("bp_beat2", 32'd7, 32'd2);
        tick();
        expect_a_beat("bp_beat3", 32'd10, 32'd3);
        tick();
        expect_a_done("bp_done");
    endtask

    task automatic test_stride();
        start_b = 1'b1; base_b = 32'd0; limit_b = 32'd10; step_b = 32'd2;
        tick();
        start_b = 1'b0;
        checks++;
        if (valid_b !== 1'b1 || out_b !== {32'd6, 32'd4, 32'd2, 32'd0} || mask_b !== 4'b1111 || index_b !== 32'd0) begin
            errors++;
            $display("FAIL stride_beat0: got valid=%0b out=%h mask=%b idx=%0d, want 1 %h 1111 0",
                     valid_b, out_b, mask_b, index_b, {32'd6, 32'd4, 32'd2, 32'd0});
        end
        tick();
        checks++;
        if (valid_b !== 1'b1 || out_b !== {32'd14, 32'd12, 32'd10, 32'd8} || mask_b !== 4'b0001 || index_b !== 32'd1) begin
            errors++;
            $display("FAIL stride_beat1: got valid=%0b out=%h mask=%b idx=%0d, want 1 %h 0001 1",
                     valid_b, out_b, mask_b, index_b, {32'd14, 32'd12, 32'd10, 32'd8});
        end
        tick();
        checks++;
        if (valid_b !== 1'b0 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL stride_done: got valid=%0b done=%0b, want 0 1", valid_b, done_b);
        end
    endtask

    task automatic test_negative_step();
        ready_a = 1'b1;
        start_dup(32'd5, 32'd0, 32'hFFFF_FFFE);
        for (int b = 0; b < 3; b++) begin
            expect_a_beat("neg_beat", 32'(5 - 2 * b), 32'(b));
            tick();
        end
        expect_a_done("neg_done");
    endtask

    task automatic test_empty();
        logic [31:0] steps [2];
        steps[0] = 32'd1;
        steps[1] = 32'd0;
        for (int t = 0; t < 2; t++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checks++;
            if (done_a !== 1'b0) begin
                errors++;
                $display("FAIL empty_pre: got done=%0b, want 0", done_a);
            end
            start_dup(32'd3, 32'd3, steps[t]);
            expect_a_done("empty_done");
        end
    endtask

    task automatic test_restart();
        ready_a = 1'b1;
        start_dup(32'd0, 32'd100, 32'd1);
        tick();
        expect_a_beat("rs_before", 32'd1, 32'd1);
        start_dup(32'd50, 32'd52, 32'd1);
        expect_a_beat("rs_new0", 32'd50, 32'd0);
        tick();
        expect_a_beat("rs_new1", 32'd51, 32'd1);
        tick();
        expect_a_done("rs_done");
    endtask

    task automatic test_overflow();
        logic [7:0] bases [2];
        logic [7:0] lims  [2];
        logic [7:0] stps  [2];
        logic [7:0] exp0  [2];
        logic [7:0] exp1  [2];
        bases[0] = 8'd120; lims[0] = 8'd127; stps[0] = 8'd5;  exp0[0] = 8'd120; exp1[0] = 8'd125;
        bases[1] = 8'h9C;  lims[1] = 8'h80;  stps[1] = 8'hEC; exp0[1] = 8'h9C;  exp1[1] = 8'h88;
        for (int t = 0; t < 2; t++) begin
            start_c = 1'b1; base_c = bases[t]; limit_c = lims[t]; step_c = stps[t];
            tick();
            start_c = 1'b0;
            checks++;
            if (valid_c !== 1'b1 || out_c !== exp0[t] || index_c !== 32'd0) begin
                errors++;
                $display("FAIL ovf_beat0 t=%0d: got valid=%0b out=%h idx=%0d, want 1 %h 0", t, valid_c, out_c, index_c, exp0[t]);
            end
            tick();
            checks++;
            if (valid_c !== 1'b1 || out_c !== exp1[t] || index_c !== 32'd1) begin
                errors++;
                $display("FAIL ovf_beat1 t=%0d: got valid=%0b out=%h idx=%0d, want 1 %h 1", t, valid_c, out_c, index_c, exp1[t]);
            end
            tick();
            checks++;
            if (valid_c !== 1'b0 || done_c !== 1'b1) begin
                errors++;
                $display("FAIL ovf_done t=%0d: got valid=%0b done=%0b out=%h, want valid=0 done=1", t, valid_c, done_c, out_c);
            end
        end
    endtask

    task automatic test_reset_midrun();
        ready_a = 1'b1;
        start_dup(32'd0, 32'd100, 32'd1);
        expect_a_beat("rm_run", 32'd0, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (valid_a !== 1'b0 || done_a !== 1'b0 || out_a !== 64'd0 || index_a !== 32'd0) begin
            errors++;
            $display("FAIL rm_reset: got valid=%0b done=%0b out=%h idx=%0d, want all 0", valid_a, done_a, out_a, index_a);
        end
        tick();
        expect_a_done("rm_done");
    endtask

    task automatic test_start_over_reset();
        ready_a = 1'b1;
        rst = 1'b1;
        start_dup(32'd2, 32'd5, 32'd1);
        rst = 1'b0;
        expect_a_beat("sr_beat0", 32'd2, 32'd0);
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL sr_done_low: got done=%0b, want 0", done_a);
        end
        tick();
        expect_a_beat("sr_beat1", 32'd3, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; base_a = '0; limit_a = '0; step_a = '0; ready_a = 1'b0;
        start_b = 1'b0; base_b = '0; limit_b = '0; step_b = '0; ready_b = 1'b0;
        start_c = 1'b0; base_c = '0; limit_c = '0; step_c = '0; ready_c = 1'b0;
        test_reset();
        test_duplicate();
        test_backpressure();
        test_stride();
        test_negative_step();
        test_empty();
        test_restart();
        test_overflow();
        test_reset_midrun();
        test_start_over_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
